// File: rtl/nlc_horner_engine.sv
`default_nettype none
// ============================================================================
// Module   : nlc_horner_engine
// Brief    : Run-time programmable, sectioned ADC non-linearity correction.
//            Horner polynomial evaluation, one MAC step per cycle.
//            Optional feature macro: NLC_SAT_EN (saturating arithmetic).
// Revision : 1.0 - initial release
// ============================================================================
module nlc_horner_engine #(
    parameter int XW     = 21,
    parameter int CW     = 32,
    parameter int CF     = 16,
    parameter int NSEC   = 4,
    parameter int MAXORD = 7,
    parameter int IW     = $clog2(MAXORD + 5)
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic signed [XW-1:0]         i_x,
    input  logic                         i_srdyi,
    output logic                         o_busy,
    output logic                         o_drop,
    output logic [CW-1:0]                o_y,
    output logic                         o_srdyo,
    output logic [$clog2(NSEC)-1:0]      o_section,
    output logic                         o_sat,
    input  logic                         i_cfg_we,
    input  logic [$clog2(NSEC)+IW-1:0]   i_cfg_addr,
    input  logic [CW-1:0]                i_cfg_data,
    output logic                         o_cfg_err
);

    localparam int c_SW    = $clog2(NSEC);
    localparam int c_I_NEG = MAXORD + 1;
    localparam int c_I_INV = MAXORD + 2;
    localparam int c_I_BND = MAXORD + 3;
    localparam int c_I_ORD = MAXORD + 4;

`ifdef NLC_SAT_EN
    localparam bit c_SAT_EN = 1'b1;
`else
    localparam bit c_SAT_EN = 1'b0;
`endif

    localparam logic signed [CW-1:0] c_MAX     = {1'b0, {(CW-1){1'b1}}};
    localparam logic signed [CW-1:0] c_MIN     = {1'b1, {(CW-1){1'b0}}};
    localparam logic signed [CW-1:0] c_ONE     = {{(CW-CF-1){1'b0}}, 1'b1, {CF{1'b0}}};
    localparam logic signed [CW-1:0] c_BND_DEF = {{(CW-XW+1){1'b0}}, {(XW-1){1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SECT = 3'd1,
        S_NORM = 3'd2,
        S_HORN = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // Returns {overflow_flag, result}; the flag is only ever raised when
    // saturation is enabled, otherwise the low CW bits wrap.
    function automatic logic [CW:0] f_sat(input logic signed [2*CW-1:0] v);
        logic          ovf;
        logic [CW-1:0] res;
        ovf = (v[2*CW-1:CW-1] != {(CW+1){v[CW-1]}});
        res = v[CW-1:0];
        if (c_SAT_EN && ovf) begin
            res = v[2*CW-1] ? c_MIN : c_MAX;
        end
        return {c_SAT_EN && ovf, res};
    endfunction

    // Section table
    logic signed [CW-1:0] r_tab_coef [NSEC][MAXORD+1];
    logic signed [CW-1:0] r_tab_neg  [NSEC];
    logic signed [CW-1:0] r_tab_inv  [NSEC];
    logic signed [CW-1:0] r_tab_bnd  [NSEC];
    logic [3:0]           r_tab_ord  [NSEC];

    // Engine state
    state_t               r_state;
    logic                 r_busy;
    logic                 r_srdyo;
    logic                 r_drop;
    logic                 r_cfg_err;
    logic                 r_sat;
    logic [CW-1:0]        r_y;
    logic [c_SW-1:0]      r_sec;
    logic signed [XW-1:0] r_x;
    logic [3:0]           r_n;
    logic [3:0]           r_k;
    logic signed [CW-1:0] r_neg;
    logic signed [CW-1:0] r_inv;
    logic signed [CW-1:0] r_t;
    logic signed [CW-1:0] r_acc;

    // A write landing on the accepting edge is held back until the sample
    // completes, so the sample sees the table as it was before the write.
    logic                 r_pend_v;
    logic [c_SW-1:0]      r_pend_sec;
    logic [IW-1:0]        r_pend_idx;
    logic [CW-1:0]        r_pend_data;

    logic [c_SW-1:0]      w_cfg_sec;
    logic [IW-1:0]        w_cfg_idx;
    logic                 w_sec_ok;
    logic                 w_cfg_ok;
    logic                 w_accept;
    logic                 w_tw_en;
    logic [c_SW-1:0]      w_tw_sec;
    logic [IW-1:0]        w_tw_idx;
    logic [CW-1:0]        w_tw_data;

    assign w_cfg_sec = i_cfg_addr[c_SW+IW-1:IW];
    assign w_cfg_idx = i_cfg_addr[IW-1:0];

    generate
        if ((2 ** c_SW) == NSEC) begin : g_secchk_full
            assign w_sec_ok = 1'b1;
        end else begin : g_secchk_part
            assign w_sec_ok = (w_cfg_sec < c_SW'(NSEC));
        end
    endgenerate

    assign w_cfg_ok = i_cfg_we && !r_busy && w_sec_ok && (w_cfg_idx <= IW'(c_I_ORD));
    assign w_accept = (r_state == S_IDLE) && i_srdyi;

    always_comb begin
        w_tw_en   = 1'b0;
        w_tw_sec  = w_cfg_sec;
        w_tw_idx  = w_cfg_idx;
        w_tw_data = i_cfg_data;
        if ((r_state == S_DONE) && r_pend_v) begin
            w_tw_en   = 1'b1;
            w_tw_sec  = r_pend_sec;
            w_tw_idx  = r_pend_idx;
            w_tw_data = r_pend_data;
        end else if (w_cfg_ok && !w_accept) begin
            w_tw_en = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int j = 0; j < NSEC; j++) begin
                for (int k = 0; k <= MAXORD; k++) begin
                    r_tab_coef[j][k] <= '0;
                end
                r_tab_neg[j] <= '0;
                r_tab_inv[j] <= c_ONE;
                r_tab_bnd[j] <= c_BND_DEF;
                r_tab_ord[j] <= '0;
            end
        end else if (w_tw_en) begin
            for (int j = 0; j < NSEC; j++) begin
                if (w_tw_sec == c_SW'(j)) begin
                    for (int k = 0; k <= MAXORD; k++) begin
                        if (w_tw_idx == IW'(k)) begin
                            r_tab_coef[j][k] <= w_tw_data;
                        end
                    end
                    if (w_tw_idx == IW'(c_I_NEG)) r_tab_neg[j] <= w_tw_data;
                    if (w_tw_idx == IW'(c_I_INV)) r_tab_inv[j] <= w_tw_data;
                    if (w_tw_idx == IW'(c_I_BND)) r_tab_bnd[j] <= w_tw_data;
                    if (w_tw_idx == IW'(c_I_ORD)) r_tab_ord[j] <= w_tw_data[3:0];
                end
            end
        end
    end

    // Datapath
    logic signed [CW-1:0]   w_xc;
    logic [c_SW-1:0]        w_sec_cnt;
    logic [3:0]             w_ord;
    logic [3:0]             w_n;
    logic [3:0]             w_cidx;
    logic signed [CW-1:0]   w_coef;
    logic signed [2*CW-1:0] w_nsum;
    logic signed [2*CW-1:0] w_nprod;
    logic signed [2*CW-1:0] w_hprod;
    logic signed [2*CW-1:0] w_hsum;
    logic [CW:0]            w_norm;
    logic [CW:0]            w_horn;

    assign w_xc = {{(CW-XW){r_x[XW-1]}}, r_x};

    always_comb begin
        w_sec_cnt = '0;
        for (int j = 0; j < NSEC - 1; j++) begin
            if (w_xc >= r_tab_bnd[j]) begin
                w_sec_cnt = w_sec_cnt + c_SW'(1);
            end
        end
    end

    assign w_ord  = r_tab_ord[w_sec_cnt];
    assign w_n    = (w_ord > 4'(MAXORD)) ? 4'(MAXORD) : w_ord;
    assign w_cidx = (r_state == S_NORM) ? r_n : r_k;

    always_comb begin
        w_coef = '0;
        for (int k = 0; k <= MAXORD; k++) begin
            if (w_cidx == 4'(k)) begin
                w_coef = r_tab_coef[r_sec][k];
            end
        end
    end

    assign w_nsum  = {{CW{w_xc[CW-1]}}, w_xc} + {{CW{r_neg[CW-1]}}, r_neg};
    assign w_nprod = w_nsum * {{CW{r_inv[CW-1]}}, r_inv};
    assign w_hprod = {{CW{r_acc[CW-1]}}, r_acc} * {{CW{r_t[CW-1]}}, r_t};
    assign w_hsum  = (w_hprod >>> CF) + {{CW{w_coef[CW-1]}}, w_coef};
    assign w_norm  = f_sat(w_nprod);
    assign w_horn  = f_sat(w_hsum);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_srdyo     <= 1'b0;
            r_drop      <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_sat       <= 1'b0;
            r_y         <= '0;
            r_sec       <= '0;
            r_x         <= '0;
            r_n         <= '0;
            r_k         <= '0;
            r_neg       <= '0;
            r_inv       <= '0;
            r_t         <= '0;
            r_acc       <= '0;
            r_pend_v    <= 1'b0;
            r_pend_sec  <= '0;
            r_pend_idx  <= '0;
            r_pend_data <= '0;
        end else begin
            r_srdyo   <= 1'b0;
            r_drop    <= i_srdyi && r_busy;
            r_cfg_err <= i_cfg_we && !w_cfg_ok;
            case (r_state)
                S_IDLE: begin
                    if (i_srdyi) begin
                        r_x         <= i_x;
                        r_busy      <= 1'b1;
                        r_sat       <= 1'b0;
                        r_pend_v    <= w_cfg_ok;
                        r_pend_sec  <= w_cfg_sec;
                        r_pend_idx  <= w_cfg_idx;
                        r_pend_data <= i_cfg_data;
                        r_state     <= S_SECT;
                    end
                end
                S_SECT: begin
                    r_sec   <= w_sec_cnt;
                    r_n     <= w_n;
                    r_neg   <= r_tab_neg[w_sec_cnt];
                    r_inv   <= r_tab_inv[w_sec_cnt];
                    r_state <= S_NORM;
                end
                S_NORM: begin
                    r_t     <= w_norm[CW-1:0];
                    r_sat   <= r_sat | w_norm[CW];
                    r_acc   <= w_coef;
                    r_k     <= r_n - 4'd1;
                    r_state <= (r_n == 4'd0) ? S_DONE : S_HORN;
                end
                S_HORN: begin
                    r_acc <= w_horn[CW-1:0];
                    r_sat <= r_sat | w_horn[CW];
                    if (r_k == 4'd0) begin
                        r_state <= S_DONE;
                    end else begin
                        r_k <= r_k - 4'd1;
                    end
                end
                S_DONE: begin
                    r_y      <= r_acc;
                    r_srdyo  <= 1'b1;
                    r_busy   <= 1'b0;
                    r_pend_v <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy    = r_busy;
    assign o_drop    = r_drop;
    assign o_y       = r_y;
    assign o_srdyo   = r_srdyo;
    assign o_section = r_sec;
    assign o_sat     = r_sat;
    assign o_cfg_err = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_nlc_horner_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_nlc_horner_engine
// Brief    : Directed and randomized bench for nlc_horner_engine against an
//            arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nlc_horner_engine;

    localparam int XW     = 21;
    localparam int CW     = 32;
    localparam int CF     = 16;
    localparam int NSEC   = 4;
    localparam int MAXORD = 7;
    localparam int IW     = 4;
    localparam int AW     = 6;

    logic                 clk = 1'b0;
    logic                 rst;
    logic signed [XW-1:0] x;
    logic                 srdyi;
    logic                 we;
    logic [AW-1:0]        addr;
    logic [CW-1:0]        data;
    logic                 o_busy, o_drop, o_srdyo, o_sat, o_cfg_err;
    logic [CW-1:0]        o_y;
    logic [1:0]           o_section;

    always #5 clk = ~clk;

    nlc_horner_engine dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_x        (x),
        .i_srdyi    (srdyi),
        .o_busy     (o_busy),
        .o_drop     (o_drop),
        .o_y        (o_y),
        .o_srdyo    (o_srdyo),
        .o_section  (o_section),
        .o_sat      (o_sat),
        .i_cfg_we   (we),
        .i_cfg_addr (addr),
        .i_cfg_data (data),
        .o_cfg_err  (o_cfg_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    int     m_coef [NSEC][MAXORD+1];
    int     m_neg  [NSEC];
    int     m_inv  [NSEC];
    int     m_bnd  [NSEC];
    int     m_ord  [NSEC];
    bit     m_busy, m_srdyo, m_drop, m_err, m_sat, p_sat, armed, ok;
    int     m_y, p_y, m_sec, p_sec, nn;
    longint cyc = 0;
    longint m_done = 0;

    function automatic longint sat_cw(input longint v, output bit f);
        f = 1'b0;
`ifdef NLC_SAT_EN
        if (v > 64'sd2147483647) begin
            f = 1'b1;
            return 64'sd2147483647;
        end
        if (v < -64'sd2147483648) begin
            f = 1'b1;
            return -64'sd2147483648;
        end
        return v;
`else
        begin
            int w;
            w = v[31:0];
            return longint'(w);
        end
`endif
    endfunction

    function automatic void ref_eval(input int xv, output int y, output int sec,
                                     output bit sat, output int n);
        longint t, acc;
        bit     f;
        sec = 0;
        for (int j = 0; j < NSEC - 1; j++) if (xv >= m_bnd[j]) sec++;
        n   = (m_ord[sec] > MAXORD) ? MAXORD : m_ord[sec];
        sat = 1'b0;
        t   = sat_cw((longint'(xv) + longint'(m_neg[sec])) * longint'(m_inv[sec]), f);
        sat |= f;
        acc = longint'(m_coef[sec][n]);
        for (int k = n - 1; k >= 0; k--) begin
            acc = sat_cw(((acc * t) >>> CF) + longint'(m_coef[sec][k]), f);
            sat |= f;
        end
        y = acc[31:0];
    endfunction

    function automatic void model_reset();
        for (int j = 0; j < NSEC; j++) begin
            for (int k = 0; k <= MAXORD; k++) m_coef[j][k] = 0;
            m_neg[j] = 0;
            m_inv[j] = 1 << CF;
            m_bnd[j] = (1 << (XW - 1)) - 1;
            m_ord[j] = 0;
        end
    endfunction

    always @(posedge clk) begin
        cyc++;
        m_srdyo = 1'b0;
        m_drop  = 1'b0;
        m_err   = 1'b0;
        if (rst) begin
            model_reset();
            m_busy = 1'b0;
            m_y    = 0;
            m_sat  = 1'b0;
            m_sec  = 0;
            armed  = 1'b1;
        end else begin
            ok     = we && !m_busy && (int'(addr[3:0]) <= MAXORD + 4);
            m_err  = we && !ok;
            m_drop = srdyi && m_busy;
            if (m_busy) begin
                if (cyc == m_done) begin
                    m_busy  = 1'b0;
                    m_srdyo = 1'b1;
                    m_y     = p_y;
                    m_sec   = p_sec;
                    m_sat   = p_sat;
                end
            end else if (srdyi) begin
                ref_eval(int'(x), p_y, p_sec, p_sat, nn);
                m_done = cyc + nn + 3;
                m_busy = 1'b1;
            end
            if (ok) begin
                if (int'(addr[3:0]) <= MAXORD) m_coef[addr[5:4]][addr[3:0]] = $signed(data);
                else if (int'(addr[3:0]) == MAXORD + 1) m_neg[addr[5:4]] = $signed(data);
                else if (int'(addr[3:0]) == MAXORD + 2) m_inv[addr[5:4]] = $signed(data);
                else if (int'(addr[3:0]) == MAXORD + 3) m_bnd[addr[5:4]] = $signed(data);
                else m_ord[addr[5:4]] = int'(data[3:0]);
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (armed) begin
            chk("busy",    o_busy,    m_busy);
            chk("srdyo",   o_srdyo,   m_srdyo);
            chk("drop",    o_drop,    m_drop);
            chk("cfg_err", o_cfg_err, m_err);
            chk("y",       o_y,       $unsigned(m_y));
            if (m_srdyo) begin
                chk("section", o_section, $unsigned(m_sec));
                chk("sat",     o_sat,     m_sat);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cfg(input int s, input int idx, input int d);
        we   = 1'b1;
        addr = {2'(s), 4'(idx)};
        data = CW'(d);
        @(negedge clk);
        we   = 1'b0;
    endtask

    task automatic wait_done(inout int lat);
        bit to;
        to = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (o_srdyo) begin
                to = 1'b0;
                break;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (to) begin
            n_cmp++;
            n_bad++;
            $display("FAIL srdyo_timeout: got no result expected one within 100 cycles");
        end
    endtask

    task automatic run_sample(input int xv, output int lat);
        x     = XW'(xv);
        srdyi = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        srdyi = 1'b0;
        wait_done(lat);
    endtask

    int lat;
    int xs [4] = '{-44979, -44978, 0, 44978};
    int d, xv;

    initial begin
        rst = 1'b1; srdyi = 1'b0; we = 1'b0; x = '0; addr = '0; data = '0;
        repeat (3) @(negedge clk);
        chk("rst_y",       o_y,       0);
        chk("rst_busy",    o_busy,    0);
        chk("rst_srdyo",   o_srdyo,   0);
        chk("rst_section", o_section, 0);
        chk("rst_sat",     o_sat,     0);
        chk("rst_drop",    o_drop,    0);
        chk("rst_cfg_err", o_cfg_err, 0);
        rst = 1'b0;
        @(negedge clk);

        // Default table
        run_sample(1234, lat);
        chk("lat_default", lat, 4);
        chk("y_default", o_y, 0);

        // Quadratic evaluation
        for (int j = 0; j < 3; j++) cfg(j, MAXORD + 3, 32767);
        cfg(0, 0, 32'h10000);
        cfg(0, 1, 32'h20000);
        cfg(0, 2, 32'h8000);
        cfg(0, MAXORD + 2, 32'h10000);
        cfg(0, MAXORD + 4, 2);
        run_sample(4, lat);
        chk("lat_horner", lat, 6);
        chk("y_horner", o_y, 32'h00110000);
        chk("sec_horner", o_section, 0);

        // Section boundaries
        cfg(0, MAXORD + 3, -44978);
        cfg(1, MAXORD + 3, 0);
        cfg(2, MAXORD + 3, 44978);
        for (int i = 0; i < 4; i++) begin
            run_sample(xs[i], lat);
            chk("sec_select", o_section, i);
        end

        // Drop and reject while busy
        for (int j = 0; j < 3; j++) cfg(j, MAXORD + 3, 32767);
        x = XW'(4); srdyi = 1'b1;
        @(negedge clk);
        we = 1'b1; addr = {2'd0, 4'd2}; data = '0;
        @(negedge clk);
        chk("drop_pulse", o_drop, 1);
        chk("reject_pulse", o_cfg_err, 1);
        srdyi = 1'b0; we = 1'b0;
        lat = 0;
        wait_done(lat);
        chk("y_after_drop", o_y, 32'h00110000);

        // Saturation
        cfg(0, 0, 0);
        cfg(0, 1, 32'h7FFF0000);
        cfg(0, MAXORD + 4, 1);
        run_sample(2, lat);
`ifdef NLC_SAT_EN
        chk("y_sat", o_y, 32'h7FFFFFFF);
        chk("sat_flag", o_sat, 1);
`else
        chk("y_wrap", o_y, 32'hFFFE0000);
        chk("sat_flag", o_sat, 0);
`endif

        // Write coinciding with accept: the sample sees the old entry
        x = XW'(2); srdyi = 1'b1;
        we = 1'b1; addr = {2'd0, 4'd1}; data = 32'h10000;
        @(negedge clk);
        srdyi = 1'b0; we = 1'b0;
        lat = 1;
        wait_done(lat);
`ifdef NLC_SAT_EN
        chk("y_prewrite", o_y, 32'h7FFFFFFF);
`else
        chk("y_prewrite", o_y, 32'hFFFE0000);
`endif
        run_sample(2, lat);
        chk("y_postwrite", o_y, 32'h00020000);
        chk("sat_clear", o_sat, 0);

        // Reset in the middle of the Horner loop
        cfg(0, MAXORD + 4, 7);
        x = XW'(4); srdyi = 1'b1;
        @(negedge clk);
        srdyi = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", o_busy, 0);
        chk("midrst_srdyo", o_srdyo, 0);
        rst = 1'b0;
        @(negedge clk);
        run_sample(4, lat);
        chk("y_after_reset", o_y, 0);
        chk("lat_after_reset", lat, 4);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            rst   = ($urandom_range(0, 399) == 0);
            srdyi = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 7) == 0) xv = int'($urandom_range(0, 2097151)) - 1048576;
            else xv = int'($urandom_range(0, 200000)) - 100000;
            x  = XW'(xv);
            we = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0: d = int'($urandom_range(0, 32'h3FFFF)) - 32'sh20000;
                1: d = int'($urandom_range(0, 100000)) - 50000;
                2: d = int'($urandom());
                default: d = 32'h10000;
            endcase
            addr = {2'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
            data = CW'(d);
            @(negedge clk);
        end
        rst = 1'b0; srdyi = 1'b0; we = 1'b0;
        repeat (40) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
